alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Multi-cycle execute-stage ALU that sits directly upstream of the flags register. It accepts an operation with a start pulse, computes the result in 1 cycle (logic/arith/shift) or iteratively (multiply), then presents result, zero flag and parity flag together with one-cycle write-enable pulses. Its z_out/p_out/flag_we drive the flags register's z_in/p_in/flag_write_enable; res_we drives register-file writeback.

Parameters:
DATA_WIDTH, 8, operand/result width in bits (≥2)
OP_WIDTH, 4, opcode width

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
op  input  OP_WIDTH  opcode, captured with start
a  input  DATA_WIDTH  operand A, captured with start
b  input  DATA_WIDTH  operand B, captured with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
result  output  DATA_WIDTH  registered result, held until next res_we
z_out  output  1  zero flag of completed op, held until next flag_we
p_out  output  1  parity flag of completed op, held until next flag_we
flag_we  output  1  one-cycle pulse with done when op updates flags
res_we  output  1  one-cycle pulse with done when op writes result
illegal  output  1  one-cycle pulse with done for undefined opcode

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; busy, done, flag_we, res_we, illegal=0; result=0; z_out=0; p_out=0. Reset wins over everything, including mid-multiply; in-flight op discarded, no done.
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a<<1; 7 SHR a>>1 (logical); 8 MUL low DATA_WIDTH bits of a*b; 9 CMP a-b, flags only; 10..15 illegal.
- All arithmetic is modulo 2^DATA_WIDTH; carries/high product bits discarded.
- z = (computed value == 0). p = even parity = XNOR-reduce of computed value (1 when number of ones is even, including 0).
- States: IDLE, MUL, DONE.
- IDLE: start=1 captures op/a/b. Single-cycle or illegal op -> DONE. MUL -> MUL with acc=0, iteration counter=0.
- MUL: shift-add, one bit of b per cycle, exactly DATA_WIDTH cycles, then -> DONE.
- DONE: done=1 for exactly one cycle; result/z_out/p_out updated at the same edge that raises done; then -> IDLE.
- Latency (start sampled at edge N): single-cycle op done at N+1; MUL done at N+DATA_WIDTH+1. busy high from N+1 through the done cycle inclusive. Max throughput: one single-cycle op every 2 cycles.
- flag_we=1 in DONE for opcodes 0–9; res_we=1 for opcodes 0–8; CMP: res_we=0, result unchanged.
- Illegal: done=1, illegal=1, flag_we=0, res_we=0; result/z_out/p_out unchanged.
- start while busy=1 (including the DONE cycle): ignored, operands not captured, no queueing.
- op/a/b changes after capture have no effect on the in-flight op.

Optional Feature:
Macro ALU_ABORT_EN. Defined: adds input port abort (1 bit). abort=1 while state=MUL returns to IDLE at next edge; no done/flag_we/res_we; result/z_out/p_out unchanged. abort is ignored in IDLE/DONE. rst has priority over abort. Undefined: no abort port; MUL always runs to completion.

Test Plan:
- ADD a=0x7F b=0x81 -> done at N+1, result=0x00, z_out=1, p_out=1, flag_we=1, res_we=1.
- SUB a=0x05 b=0x03 -> result=0x02, z_out=0, p_out=0; busy high only in cycle N+1.
- MUL a=0x0C b=0x0B -> busy N+1..N+9, done at N+9, result=0x84, z_out=0, p_out=1; start pulses at N+3 ignored.
- After ADD gives result=0x42: CMP a=0x10 b=0x10 -> z_out=1, p_out=1, flag_we=1, res_we=0, result stays 0x42.
- op=0xF -> done=1, illegal=1, flag_we=0, res_we=0, flags/result unchanged. Separately, rst=1 at N+4 of a MUL -> next cycle busy=0, result=0, no done ever.
- With ALU_ABORT_EN: MUL 0x03*0x03, abort at N+3 -> busy=0 at N+4, no done; a following ADD 0x01+0x01 completes normally with result=0x02.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute ALU: single-cycle logic/arith/shift ops, shift-add multiply, zero/parity flags.
// Optional macro ALU_ABORT_EN adds an abort input that cancels an in-flight multiply.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
`ifdef ALU_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  z_out,
  output logic                  p_out,
  output logic                  flag_we,
  output logic                  res_we,
  output logic                  illegal
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_CMP = OP_WIDTH'(9);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   m_r, b_r, acc, acc_nxt, calc_val;
  logic [CNT_W-1:0]        cnt;
  logic                    accept, mul_last, mul_finish, abort_w;

  function automatic logic [DATA_WIDTH-1:0] alu_calc(input logic [OP_WIDTH-1:0] f_op,
                                                     input logic [DATA_WIDTH-1:0] f_a,
                                                     input logic [DATA_WIDTH-1:0] f_b);
    alu_calc = '0;
    case (f_op)
      OP_ADD:         alu_calc = f_a + f_b;
      OP_SUB, OP_CMP: alu_calc = f_a - f_b;
      OP_AND:         alu_calc = f_a & f_b;
      OP_OR:          alu_calc = f_a | f_b;
      OP_XOR:         alu_calc = f_a ^ f_b;
      OP_NOT:         alu_calc = ~f_a;
      OP_SHL:         alu_calc = f_a << 1;
      OP_SHR:         alu_calc = f_a >> 1;
      default:        alu_calc = '0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [OP_WIDTH-1:0] f_op);
    is_legal = (f_op <= OP_CMP);
  endfunction

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] v);
    even_parity = ~^v;
  endfunction

`ifdef ALU_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) && start;
  assign calc_val   = alu_calc(op, a, b);
  assign acc_nxt    = acc + (b_r[0] ? m_r : '0);
  assign mul_last   = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign mul_finish = (state == MUL) && mul_last && !abort_w;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op == OP_MUL) ? MUL : DONE;
      MUL: begin
        if (abort_w)       state_nxt = IDLE;
        else if (mul_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture / shift-add iteration (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      m_r <= a;
      b_r <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == MUL) begin
      acc <= acc_nxt;
      m_r <= m_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt + 1'b1;
    end
  end

  // Completion stage: result, flags and write-enable pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      flag_we <= 1'b0;
      res_we  <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
      z_out   <= 1'b0;
      p_out   <= 1'b0;
    end else begin
      done    <= 1'b0;
      flag_we <= 1'b0;
      res_we  <= 1'b0;
      illegal <= 1'b0;
      if (accept && (op != OP_MUL)) begin
        done <= 1'b1;
        if (is_legal(op)) begin
          flag_we <= 1'b1;
          z_out   <= (calc_val == '0);
          p_out   <= even_parity(calc_val);
          if (op != OP_CMP) begin
            res_we <= 1'b1;
            result <= calc_val;
          end
        end else begin
          illegal <= 1'b1;
        end
      end else if (mul_finish) begin
        done    <= 1'b1;
        flag_we <= 1'b1;
        res_we  <= 1'b1;
        result  <= acc_nxt;
        z_out   <= (acc_nxt == '0);
        p_out   <= even_parity(acc_nxt);
      end
    end
  end

endmodule
